// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Instruction memory loader. Accepts a stream of addressed
//                32-bit instruction words into a DEPTH-word RAM, tracks how
//                many words were accepted, flags stream errors, and holds the
//                CPU in reset until the upstream stream reports completion.
//                The CPU fetches through a registered, read-first port.
//                Optional feature macro: CHECKSUM_EN adds a 32-bit running
//                sum of accepted words on the checksum output.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6      // DEPTH must equal 2**ADDR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [31:0]         in_data,
    input  logic [31:0]         in_addr,
    input  logic                in_done,
    input  logic [ADDR_W-1:0]   fetch_addr,
    output logic [31:0]         fetch_data,
    output logic                cpu_rst,
    output logic [ADDR_W:0]     load_count,
    output logic                load_error
`ifdef CHECKSUM_EN
    ,
    output logic [31:0]         checksum
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                c_cnt_w     = ADDR_W + 1;
    localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
    localparam logic [31:0]       c_depth_32  = 32'(DEPTH);

    // ------------------------------------------------------------------------
    // State encoding: RUN is terminal until rst
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOADING = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    // ------------------------------------------------------------------------
    // Storage and registered outputs
    // ------------------------------------------------------------------------
    logic [31:0]          r_mem [DEPTH];
    logic [31:0]          r_fetch_data;
    logic [c_cnt_w-1:0]   r_load_count;
    logic                 r_load_error;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic                 w_wr_cycle;    // a word is presented while loading is open
    logic                 w_addr_ok;     // presented address falls inside the RAM
    logic                 w_accept;      // word is written this edge
    logic                 w_drop;        // word discarded, out-of-range address
    logic                 w_nonseq;      // accepted word out of sequence
    logic [c_cnt_w-1:0]   w_count_next;
    logic                 w_enter_run;
    logic                 w_empty_run;   // entering RUN without any loaded word
    logic                 w_error_next;

    // Next-state selection for the load sequencer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_done) begin
                    w_state_next = S_RUN;
                end else if (in_valid) begin
                    w_state_next = S_LOADING;
                end
            end
            S_LOADING: begin
                if (in_done) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Accept/error decode; the word seen alongside the first in_done is still accepted
    always_comb begin
        w_wr_cycle   = in_valid && (r_state != S_RUN);
        w_addr_ok    = (in_addr < c_depth_32);
        w_accept     = w_wr_cycle && w_addr_ok;
        w_drop       = w_wr_cycle && !w_addr_ok;
        w_nonseq     = w_accept && (in_addr != 32'(r_load_count));
        w_count_next = r_load_count;
        if (w_accept && (r_load_count != c_depth_cnt)) begin
            w_count_next = r_load_count + 1'b1;
        end
        // Empty check uses the post-accept count so a lone word arriving with
        // in_done does not count as an empty image.
        w_enter_run  = (r_state != S_RUN) && (w_state_next == S_RUN);
        w_empty_run  = w_enter_run && (w_count_next == '0);
        w_error_next = r_load_error | w_drop | w_nonseq | w_empty_run;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Load counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_load_count <= '0;
            r_load_error <= 1'b0;
        end else begin
            r_load_count <= w_count_next;
            r_load_error <= w_error_next;
        end
    end

    // Instruction RAM write port; contents deliberately survive rst
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[in_addr[ADDR_W-1:0]] <= in_data;
        end
    end

    // Registered fetch port; non-blocking read gives old data on a same-address write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_data <= '0;
        end else begin
            r_fetch_data <= r_mem[fetch_addr];
        end
    end

`ifdef CHECKSUM_EN
    logic [31:0] r_checksum;

    // Running modulo-2^32 sum of accepted words; no accepts occur in RUN so it freezes there
    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + in_data;
        end
    end

    assign checksum = r_checksum;
`endif

    // ------------------------------------------------------------------------
    // Outputs; CPU leaves reset on the first cycle the state register is RUN
    // ------------------------------------------------------------------------
    assign cpu_rst    = (r_state != S_RUN);
    assign fetch_data = r_fetch_data;
    assign load_count = r_load_count;
    assign load_error = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader. Covers reset
//                values, sequential loading, out-of-range and non-sequential
//                words, empty image, abort/reload, read-first fetch, count
//                saturation and (with CHECKSUM_EN) the running checksum.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [31:0]       in_data;
    logic [31:0]       in_addr;
    logic              in_done;
    logic [ADDR_W-1:0] fetch_addr;
    logic [31:0]       fetch_data;
    logic              cpu_rst;
    logic [ADDR_W:0]   load_count;
    logic              load_error;
`ifdef CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    imem_loader #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_addr    (in_addr),
        .in_done    (in_done),
        .fetch_addr (fetch_addr),
        .fetch_data (fetch_data),
        .cpu_rst    (cpu_rst),
        .load_count (load_count),
        .load_error (load_error)
`ifdef CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1ns so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_done  = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic put_word(input logic [31:0] a, input logic [31:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic finish_stream();
        in_done = 1'b1;
        tick();
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        fetch_addr = a;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_addr    = '0;
        in_done    = 1'b0;
        fetch_addr = '0;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_cpu_rst",    32'(cpu_rst),    32'd1);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_load_error", 32'(load_error), 32'd0);
        check("rst_fetch_data", fetch_data,      32'd0);
`ifdef CHECKSUM_EN
        check("rst_checksum",   checksum,        32'd0);
`endif

        // ---------------- 28-word sequential stream ----------------
        for (int a = 0; a < 28; a++) begin
            put_word(32'(a), 32'h1000 + 32'(a));
        end
        check("seq_count_pre", 32'(load_count), 32'd28);
        in_done = 1'b1;
        #1;
        check("seq_cpu_rst_before_edge", 32'(cpu_rst), 32'd1);
        tick();
        check("seq_cpu_rst_run", 32'(cpu_rst),    32'd0);
        check("seq_count",       32'(load_count), 32'd28);
        check("seq_error",       32'(load_error), 32'd0);
        fetch(6'd5);
        check("seq_fetch5",  fetch_data, 32'h0000_1005);
        fetch(6'd27);
        check("seq_fetch27", fetch_data, 32'h0000_101B);
        // Writes in RUN are ignored
        put_word(32'd5, 32'hDEAD_BEEF);
        fetch(6'd5);
        check("run_ignore_write", fetch_data,      32'h0000_1005);
        check("run_ignore_count", 32'(load_count), 32'd28);
        check("run_ignore_error", 32'(load_error), 32'd0);

        // ---------------- out-of-range word mid-stream ----------------
        do_reset();
        check("reset_after_run_cpu", 32'(cpu_rst), 32'd1);
        put_word(32'd0, 32'h2000);
        put_word(32'd1, 32'h2001);
        check("oor_err_before", 32'(load_error), 32'd0);
        put_word(32'd64, 32'h0000_0BAD);
        check("oor_error", 32'(load_error), 32'd1);
        check("oor_count", 32'(load_count), 32'd2);
        put_word(32'd2, 32'h2002);
        // Last word arrives together with in_done and must still be taken
        in_valid = 1'b1;
        in_addr  = 32'd3;
        in_data  = 32'h2003;
        in_done  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("done_word_count", 32'(load_count), 32'd4);
        check("done_word_cpu",   32'(cpu_rst),    32'd0);
        fetch(6'd0);
        check("oor_mem0_intact", fetch_data, 32'h0000_2000);
        fetch(6'd3);
        check("done_word_mem3",  fetch_data, 32'h0000_2003);

        // ---------------- non-sequential addresses 0,1,3 ----------------
        do_reset();
        put_word(32'd0, 32'h3000);
        put_word(32'd1, 32'h3001);
        check("nseq_err_before", 32'(load_error), 32'd0);
        put_word(32'd3, 32'h3003);
        check("nseq_error", 32'(load_error), 32'd1);
        check("nseq_count", 32'(load_count), 32'd3);
        finish_stream();
        fetch(6'd3);
        check("nseq_mem3", fetch_data, 32'h0000_3003);

        // ---------------- empty image ----------------
        do_reset();
        finish_stream();
        check("empty_cpu_rst", 32'(cpu_rst),    32'd0);
        check("empty_error",   32'(load_error), 32'd1);
        check("empty_count",   32'(load_count), 32'd0);

        // ---------------- read-first, abort mid-load, reload ----------------
        do_reset();
        fetch_addr = 6'd0;
        put_word(32'd0, 32'h5000);
        check("read_first_old", fetch_data, 32'h0000_3000);
        put_word(32'd1, 32'h5001);
        check("read_first_new", fetch_data, 32'h0000_5000);
        for (int a = 2; a < 10; a++) begin
            put_word(32'(a), 32'h5000 + 32'(a));
        end
        check("abort_pre_count", 32'(load_count), 32'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_count", 32'(load_count), 32'd0);
        check("abort_cpu",   32'(cpu_rst),    32'd1);
        for (int a = 0; a < 4; a++) begin
            put_word(32'(a), 32'hA + 32'(a));
        end
        finish_stream();
        check("reload_count", 32'(load_count), 32'd4);
        check("reload_error", 32'(load_error), 32'd0);
        for (int a = 0; a < 4; a++) begin
            fetch(6'(a));
            check($sformatf("reload_mem%0d", a), fetch_data, 32'hA + 32'(a));
        end
        fetch(6'd9);
        check("reload_mem9_old", fetch_data, 32'h0000_5009);

        // ---------------- full image and count saturation ----------------
        do_reset();
        for (int a = 0; a < DEPTH; a++) begin
            put_word(32'(a), 32'h7000 + 32'(a));
        end
        check("full_count", 32'(load_count), 32'd64);
        check("full_error", 32'(load_error), 32'd0);
        put_word(32'd0, 32'h7777);
        check("sat_count", 32'(load_count), 32'd64);
        check("sat_error", 32'(load_error), 32'd1);
        finish_stream();
        fetch(6'd63);
        check("full_mem63", fetch_data, 32'h0000_703F);
        fetch(6'd0);
        check("sat_mem0_rewritten", fetch_data, 32'h0000_7777);

`ifdef CHECKSUM_EN
        // ---------------- checksum wrap and freeze ----------------
        do_reset();
        check("cks_reset", checksum, 32'd0);
        put_word(32'd0, 32'hFFFF_FFFF);
        check("cks_first", checksum, 32'hFFFF_FFFF);
        put_word(32'd1, 32'h0000_0002);
        check("cks_wrap", checksum, 32'h0000_0001);
        finish_stream();
        put_word(32'd2, 32'h0000_0005);
        check("cks_frozen", checksum, 32'h0000_0001);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 64, number of 32-bit instruction words stored.
REQ-002 Parameter ADDR_W, default 6, fetch address width; DEPTH SHALL equal 2**ADDR_W.
REQ-003 clk  input  1  rising-edge clock for all logic.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream word valid, one write per cycle when high.
REQ-006 in_data  input  32  instruction word.
REQ-007 in_addr  input  32  word address of in_data.
REQ-008 in_done  input  1  upstream stream complete; level, stays high once set.
REQ-009 fetch_addr  input  ADDR_W  CPU instruction fetch word address.
REQ-010 fetch_data  output  32  registered fetch read data.
REQ-011 cpu_rst  output  1  holds CPU in reset until image loaded.
REQ-012 load_count  output  ADDR_W+1  number of accepted words.
REQ-013 load_error  output  1  sticky stream error flag.
REQ-014 checksum  output  32  running sum of accepted words; present only with CHECKSUM_EN.

Function
REQ-015 The block SHALL implement states IDLE, LOADING, RUN; RUN is terminal until rst.
REQ-016 IDLE->LOADING on in_valid=1 and in_done=0; IDLE->RUN on in_done=1; LOADING->RUN on in_done=1.
REQ-017 A word is accepted when in_valid=1, state is IDLE or LOADING, and in_addr<DEPTH; this includes the cycle in which in_done is first seen.
REQ-018 An accepted word SHALL be written to mem[in_addr[ADDR_W-1:0]] at that clock edge and load_count SHALL increment by 1, saturating at DEPTH.
REQ-019 in_valid=1 with in_addr>=DEPTH SHALL discard the word, leave load_count unchanged, and set load_error.
REQ-020 An accepted word whose in_addr differs from load_count (non-sequential) SHALL be written and SHALL set load_error.
REQ-021 Entering RUN with load_count=0 SHALL set load_error.
REQ-022 In RUN, in_valid, in_data and in_addr SHALL be ignored; no memory writes occur.
REQ-023 cpu_rst SHALL be 1 in IDLE and LOADING and SHALL go 0 on the first cycle the state register equals RUN (one cycle after in_done is sampled), regardless of load_error.
REQ-024 fetch_data SHALL equal mem[fetch_addr] sampled at the previous edge (1-cycle latency) in every state.
REQ-025 A same-cycle write and fetch to one address SHALL return the old contents (read-first).
REQ-026 Memory contents SHALL NOT be cleared by rst; unwritten words read as 0 after configuration.

Reset
REQ-027 On rst: state=IDLE, cpu_rst=1, load_count=0, load_error=0, fetch_data=0, checksum=0.
REQ-028 rst asserted mid-LOADING or in RUN SHALL abort immediately; the next stream reloads from IDLE and overwrites memory.

Configuration
REQ-029 Macro CHECKSUM_EN: when defined, checksum port exists and adds each accepted in_data modulo 2**32 at the accept edge; it freezes in RUN.
REQ-030 Without CHECKSUM_EN, the checksum port and adder SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Stream 28 words, addr 0..27, data=0x1000+addr, in_done one cycle after last -> load_count=28, load_error=0, cpu_rst falls 1 cycle after in_done, fetch_addr=5 gives 0x1005 next cycle.
REQ-032 Word at addr 64 mid-stream -> discarded, load_error=1, load_count unchanged, memory[0] intact.
REQ-033 Addresses 0,1,3 -> all three written, load_error=1 on the addr-3 edge, load_count=3.
REQ-034 in_done=1 with no prior words -> RUN, load_error=1, cpu_rst=0, load_count=0.
REQ-035 rst after 10 words, then a fresh 4-word stream of 0xA..0xD -> load_count=4, error=0, mem[0..3]=0xA..0xD, mem[9] still holds old value.
REQ-036 CHECKSUM_EN: words 0xFFFFFFFF,0x2 -> checksum=0x00000001; in_valid words after RUN leave it unchanged.
